ram_read_streamer: RTL and testbench
====================================

# ram_read_streamer

Converts the registered 1-cycle-latency read port of the `Ram_1w_1rs` simple dual-port RAM into a valid/ready command/response stream pair with full backpressure and no throughput loss. It sits directly on the RAM read port. It accepts addresses, drives `rd_en`/`rd_addr`, captures `rd_data` one cycle later into a 2-entry response buffer, and presents ordered responses downstream. Optionally it snoops the RAM write port to give defined new-data semantics on same-cycle read/write collisions.

## Interface
- ADDR_WIDTH, 10, RAM address width; equals the RAM's rd/wr address width.
- DATA_WIDTH, 32, word width; equals the RAM's rd/wr data width.
- MASK_WIDTH, 4, write-mask lanes; DATA_WIDTH must be divisible by MASK_WIDTH.

Ports:
- clk  in  1  single clock; drives the RAM's `wr_clk` and `rd_clk`.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  read command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  ADDR_WIDTH  read address.
- ram_rd_en  out  1  connects to the RAM `rd_en`.
- ram_rd_addr  out  ADDR_WIDTH  connects to the RAM `rd_addr`.
- ram_rd_data  in  DATA_WIDTH  connects to the RAM `rd_data`.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  downstream accepts the response.
- rsp_data  out  DATA_WIDTH  response word, in command order.
- snoop_wr_en  in  1  copy of the RAM `wr_en`.
- snoop_wr_mask  in  MASK_WIDTH  copy of the RAM `wr_mask`.
- snoop_wr_addr  in  ADDR_WIDTH  copy of the RAM `wr_addr`.
- snoop_wr_data  in  DATA_WIDTH  copy of the RAM `wr_data`.

## Operation
- State:
  - `inflight` (1 bit): a read was issued last cycle.
  - 2-entry response FIFO with `count` (0..2).
- `pop = rsp_valid & rsp_ready`.
- `cmd_ready = !reset & (count + inflight - pop < 2)`. This path is combinational from rsp_ready, by design.
- `ram_rd_en = cmd_valid & cmd_ready`.
- `ram_rd_addr = cmd_addr`, combinational passthrough.
- `inflight <= ram_rd_en` each cycle.
- When `inflight` is high, the returned word is pushed into the FIFO at the end of that cycle.
- Push and pop in the same cycle: count is unchanged.
- Credit rule guarantees no push occurs while count==2 without a simultaneous pop. Overflow is a design error; assert it in simulation.
- `rsp_valid = (count != 0)`.
- `rsp_data` = FIFO head. It is held stable while `rsp_valid & !rsp_ready`.
- Responses leave in exact command order; nothing is dropped or duplicated.

## Timing
- Reset values:
  - cmd_ready=0 while reset is high.
  - ram_rd_en=0.
  - rsp_valid=0, count=0, inflight=0.
  - rsp_data is don't-care.
- Reset mid-operation discards the in-flight read and all buffered responses. cmd_ready may rise in the first cycle after reset deasserts.
- Latency: command accepted in cycle t → rsp_valid in cycle t+2, provided the FIFO was empty.
- Throughput: 1 response per cycle sustained when rsp_ready is held high.
- Stall: rsp_ready=0 fills the FIFO. Up to 2 further commands are accepted after stall onset, then cmd_ready=0 until a pop.
- cmd_ready can rise in the same cycle a pop frees space.

## Configuration
- `RAM_READ_STREAMER_RUW_FWD_EN` defined (read-under-write forwarding):
  - In the issue cycle, if `snoop_wr_en & snoop_wr_addr == cmd_addr`, register snoop_wr_mask and snoop_wr_data alongside `inflight`.
  - Next cycle, the pushed word takes lane i from the registered write data where mask[i]=1, and from ram_rd_data otherwise.
  - Net effect: a same-cycle collision returns the newly written lanes.
  - Writes in any other cycle do not affect the captured word.
- Undefined:
  - Snoop ports are ignored (leave unconnected or tie to 0).
  - Collided reads return whatever ram_rd_data holds, i.e. the RAM's dontCare.
  - No forwarding registers are instantiated.

## Structure
- Package `ram_read_streamer_pkg`:
  - localparam `FIFO_DEPTH = 2`.
  - Count type, 2 bits.
  - Lane-width function `DATA_WIDTH/MASK_WIDTH`.
- Sub-module `ram_read_streamer_fifo`:
  - 2-entry register FIFO with push/pop/count and head output.
  - Instantiated once.
  - Credit logic and forwarding merge stay in the top.

## Test plan
- Single read, with RAM[5]=0xDEADBEEF and rsp_ready=1: cmd addr 5 accepted at t → rsp_valid at t+2 with rsp_data=0xDEADBEEF; rsp_valid=0 at t+3.
- Back-to-back reads of addresses 0..15 with rsp_ready=1: cmd_ready stays 1, 16 consecutive responses in order, no bubbles.
- Backpressure: rsp_ready=0 from the start while 4 commands are offered → exactly 2 accepted, then cmd_ready=0, rsp_data stable. Raise rsp_ready → remaining 2 accepted, all 4 returned in order.
- Reset pulse one cycle after issuing 2 reads → rsp_valid=0 and count=0 after reset; no stale responses emerge.
- Forwarding (macro on): RAM[7]=0x11223344; read addr 7 in the same cycle as a write of 0xAABBCCDD with mask 4'b0101 → rsp_data=0x11BB33DD.
- Random valid/ready (10k cycles) against a scoreboard model of the RAM: no loss, no duplication, order preserved, FIFO never overflows.

Source files
------------

// File: rtl/ram_read_streamer_pkg.sv
// Shared types and constants for the RAM read-port streamer.
package ram_read_streamer_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [1:0] count_t;

  function automatic int unsigned lane_width(input int unsigned data_width,
                                             input int unsigned mask_width);
    return data_width / mask_width;
  endfunction

endpackage

// File: rtl/ram_read_streamer_fifo.sv
// Two-entry register FIFO holding captured read responses; head is the oldest word.
module ram_read_streamer_fifo
  import ram_read_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output count_t                count
);

  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      assert (!(push && !pop && count == 2'(FIFO_DEPTH)));
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Head only moves on a pop or when filling an empty FIFO, so it stays stable under stall.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (count == 2'd2) begin
        head <= tail;
        tail <= push_data;
      end else begin
        head <= push_data;
      end
    end else if (pop) begin
      head <= tail;
    end else if (push) begin
      if (count == 2'd0) head <= push_data;
      else               tail <= push_data;
    end
  end

endmodule

// File: rtl/ram_read_streamer.sv
// Valid/ready command/response wrapper around a 1-cycle registered RAM read port.
// Define RAM_READ_STREAMER_RUW_FWD_EN to forward same-cycle write lanes into the response.
module ram_read_streamer
  import ram_read_streamer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  snoop_wr_en,
  input  logic [MASK_WIDTH-1:0] snoop_wr_mask,
  input  logic [ADDR_WIDTH-1:0] snoop_wr_addr,
  input  logic [DATA_WIDTH-1:0] snoop_wr_data
);

  logic                  inflight;
  count_t                count;
  logic                  pop_c;
  logic [2:0]            occ_c;
  logic [DATA_WIDTH-1:0] push_data_c;

  // Credit: buffered plus in-flight words, less the one leaving this cycle, must leave a free slot.
  assign pop_c       = rsp_valid & rsp_ready;
  assign occ_c       = 3'(count) + 3'(inflight) - 3'(pop_c);
  assign cmd_ready   = !reset && (occ_c < 3'(FIFO_DEPTH));
  assign ram_rd_en   = cmd_valid & cmd_ready;
  assign ram_rd_addr = cmd_addr;
  assign rsp_valid   = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= ram_rd_en;
  end

`ifdef RAM_READ_STREAMER_RUW_FWD_EN
  localparam int unsigned LANE_W = lane_width(DATA_WIDTH, MASK_WIDTH);

  logic                  fwd_hit;
  logic [MASK_WIDTH-1:0] fwd_mask;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Capture a write colliding with the issued read so its lanes override the RAM word.
  always_ff @(posedge clk) begin
    if (reset) fwd_hit <= 1'b0;
    else       fwd_hit <= ram_rd_en && snoop_wr_en && (snoop_wr_addr == cmd_addr);
    fwd_mask <= snoop_wr_mask;
    fwd_data <= snoop_wr_data;
  end

  always_comb begin
    push_data_c = ram_rd_data;
    for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
      if (fwd_hit && fwd_mask[i])
        push_data_c[i*LANE_W +: LANE_W] = fwd_data[i*LANE_W +: LANE_W];
    end
  end
`else
  logic unused_snoop;

  assign push_data_c  = ram_rd_data;
  assign unused_snoop = ^{snoop_wr_en, snoop_wr_mask, snoop_wr_addr, snoop_wr_data};
`endif

  ram_read_streamer_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data(push_data_c),
    .pop      (pop_c),
    .head     (rsp_data),
    .count    (count)
  );

endmodule

// File: tb/tb_ram_read_streamer.sv
// Self-checking bench for ram_read_streamer with a behavioural 1-cycle-latency RAM and scoreboard.
module tb_ram_read_streamer;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          wr_en = 1'b0;
  logic [MW-1:0] wr_mask = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] ram     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] exp_q   [$];

  int            n_checks = 0;
  int            n_errors = 0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always #5 clk = ~clk;

  ram_read_streamer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MASK_WIDTH(MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .snoop_wr_en  (wr_en),
    .snoop_wr_mask(wr_mask),
    .snoop_wr_addr(wr_addr),
    .snoop_wr_data(wr_data)
  );

  // Masked-write RAM with registered read returning pre-write data.
  always @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_mask[i]) ram[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef RAM_READ_STREAMER_RUW_FWD_EN
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction
`endif

  // One clock: drive at negedge, sample/score before the next posedge.
  task automatic step(input logic cv, input logic [AW-1:0] ca, input logic rr,
                      input logic we, input logic [MW-1:0] wm, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd,
                      output logic cr_o, output logic rv_o, output logic [DW-1:0] rd_o);
    logic [DW-1:0] exp_w;
    @(negedge clk);
    cmd_valid = cv; cmd_addr = ca; rsp_ready = rr;
    wr_en = we; wr_mask = wm; wr_addr = wa; wr_data = wd;
    #1;
    cr_o = cmd_ready; rv_o = rsp_valid; rd_o = rsp_data;
    if (!reset) begin
      if (hold_pending) check("hold_stable", rsp_data, hold_data);
      hold_pending = rsp_valid && !rr;
      hold_data    = rsp_data;
      if (rsp_valid && rr) begin
        if (exp_q.size() == 0) check("rsp_extra", 32'(rsp_valid), 32'(0));
        else                   check("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (cv && cmd_ready) begin
        exp_w = ref_mem[ca];
`ifdef RAM_READ_STREAMER_RUW_FWD_EN
        if (we && wa == ca) exp_w = merge(exp_w, wd, wm);
`endif
        exp_q.push_back(exp_w);
      end
    end else begin
      hold_pending = 1'b0;
    end
    if (we)
      for (int i = 0; i < 4; i++)
        if (wm[i]) ref_mem[wa][i*8 +: 8] = wd[i*8 +: 8];
    @(posedge clk);
    if (reset) exp_q.delete();
  endtask

  task automatic idle(input logic rr, output logic cr_o, output logic rv_o, output logic [DW-1:0] rd_o);
    step(1'b0, '0, rr, 1'b0, '0, '0, '0, cr_o, rv_o, rd_o);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic c, v;
    logic [DW-1:0] r;
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, a, d, c, v, r);
  endtask

  task automatic drain(input string tag);
    logic c, v;
    logic [DW-1:0] r;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) idle(1'b1, c, v, r);
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cr, rv;
    logic [DW-1:0] rd;
    int acc;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, cr, rv, rd);
      check("reset_cmd_ready", 32'(cr), 32'(0));
    end
    reset = 1'b0;
    idle(1'b1, cr, rv, rd);
    check("post_reset_rsp_valid", 32'(rv), 32'(0));
    check("post_reset_cmd_ready", 32'(cr), 32'(1));

    for (int a = 0; a < 64; a++) write_word(AW'(a), $urandom);

    // Single read latency
    write_word(10'd5, 32'hDEADBEEF);
    step(1'b1, 10'd5, 1'b1, 1'b0, '0, '0, '0, cr, rv, rd);
    check("single_accept", 32'(cr), 32'(1));
    idle(1'b1, cr, rv, rd);
    check("single_t1_valid", 32'(rv), 32'(0));
    idle(1'b1, cr, rv, rd);
    check("single_t2_valid", 32'(rv), 32'(1));
    check("single_t2_data", rd, 32'hDEADBEEF);
    idle(1'b1, cr, rv, rd);
    check("single_t3_valid", 32'(rv), 32'(0));

    // Back-to-back streaming, no bubbles
    for (int k = 0; k < 18; k++) begin
      logic ev;
      ev = (k >= 2);
      step(k < 16, AW'(k), 1'b1, 1'b0, '0, '0, '0, cr, rv, rd);
      if (k < 16) check("b2b_cmd_ready", 32'(cr), 32'(1));
      check("b2b_rsp_valid", 32'(rv), 32'(ev));
    end
    drain("b2b_drained");

    // Backpressure: two credits, then stall until pops
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      step(acc < 4, AW'(20 + acc), 1'b0, 1'b0, '0, '0, '0, cr, rv, rd);
      if (acc < 4 && cr) acc++;
    end
    check("bp_accepted", 32'(acc), 32'(2));
    check("bp_cmd_ready", 32'(cr), 32'(0));
    check("bp_rsp_valid", 32'(rv), 32'(1));
    for (int k = 0; k < 20 && acc < 4; k++) begin
      step(1'b1, AW'(20 + acc), 1'b1, 1'b0, '0, '0, '0, cr, rv, rd);
      if (cr) acc++;
    end
    check("bp_all_accepted", 32'(acc), 32'(4));
    drain("bp_drained");

    // Reset mid-operation discards in-flight and buffered reads
    step(1'b1, 10'd30, 1'b0, 1'b0, '0, '0, '0, cr, rv, rd);
    step(1'b1, 10'd31, 1'b0, 1'b0, '0, '0, '0, cr, rv, rd);
    reset = 1'b1;
    idle(1'b0, cr, rv, rd);
    check("midreset_cmd_ready", 32'(cr), 32'(0));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(1'b1, cr, rv, rd);
      check("midreset_no_stale", 32'(rv), 32'(0));
      if (k == 0) check("midreset_ready_rise", 32'(cr), 32'(1));
    end

`ifdef RAM_READ_STREAMER_RUW_FWD_EN
    write_word(10'd7, 32'h11223344);
    step(1'b1, 10'd7, 1'b1, 1'b1, 4'b0101, 10'd7, 32'hAABBCCDD, cr, rv, rd);
    idle(1'b1, cr, rv, rd);
    idle(1'b1, cr, rv, rd);
    check("fwd_valid", 32'(rv), 32'(1));
    check("fwd_data", rd, 32'h11BB33DD);
    drain("fwd_drained");
`endif

    // Random traffic against the scoreboard
    for (int k = 0; k < 10000; k++) begin
      logic [AW-1:0] ca, wa;
      ca = AW'($urandom_range(0, 63));
      wa = ($urandom_range(0, 7) == 0) ? ca : AW'($urandom_range(0, 63));
      step(1'($urandom_range(0, 1)), ca, ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), MW'($urandom), wa, $urandom, cr, rv, rd);
    end
    drain("random_drained");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
